// File: rtl/brick_field.sv
// Brick wall for the breakout game: turns erase requests from the ball into hit counts,
// keeps score/bricks-left/cleared, and renders the wall with one clock of latency.
// Optional macro BLOCK_BORDER_EN draws a 2-pixel white border around each live brick.
module brick_field #(
    parameter int NUM_BLOCKS      = 10,
    parameter int HITS_TO_CLEAR   = 3,
    parameter int BLOCK_WIDTH     = 80,
    parameter int BLOCK_HEIGHT    = 30,
    parameter int BLOCK_SPACING_X = 40,
    parameter int FIRST_ROW_Y     = 40,
    parameter int SECOND_ROW_Y    = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       erase_enable,
    input  logic [5:0] e_pos,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    output logic       block_on,
    output logic [7:0] block_rgb,
    output logic [3:0] blocks_left,
    output logic       all_cleared,
    output logic [9:0] score
);

    localparam int HW         = $clog2(HITS_TO_CLEAR + 1);
    localparam int PER_ROW    = 5;
    localparam int PITCH_X    = BLOCK_WIDTH + BLOCK_SPACING_X;
    localparam int BORDER_PIX = 2;

    localparam logic [HW-1:0] HIT_MAX = HW'(HITS_TO_CLEAR);
    localparam logic [7:0] RGB_HIT0   = 8'hE0;
    localparam logic [7:0] RGB_HIT1   = 8'hFC;
    localparam logic [7:0] RGB_HIT2   = 8'h1C;
    localparam logic [7:0] RGB_BORDER = 8'hFF;

    logic [HW-1:0] hit_q [NUM_BLOCKS];
    logic [HW-1:0] hit_d [NUM_BLOCKS];
    logic          prev_en_q;
    logic [5:0]    prev_pos_q;
    logic [9:0]    score_q, score_d;
    logic [3:0]    blocks_left_q, blocks_left_d;
    logic          all_cleared_q;
    logic          block_on_q, block_on_d;
    logic [7:0]    block_rgb_q, block_rgb_d;

    logic          erase_event;
    logic          target_live;
    logic          accept;

    // A held erase_enable only counts again once the target index changes.
    assign erase_event = erase_enable && (!prev_en_q || (e_pos != prev_pos_q));

    always_comb begin
        target_live = 1'b0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (e_pos == 6'(i) && hit_q[i] < HIT_MAX) begin
                target_live = 1'b1;
            end
        end
    end

    assign accept = erase_event && (e_pos < 6'(NUM_BLOCKS)) && target_live;

    always_comb begin
        score_d       = score_q;
        blocks_left_d = blocks_left_q;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            hit_d[i] = hit_q[i];
        end
        if (accept) begin
            if (score_q != 10'd1023) begin
                score_d = score_q + 10'd1;
            end
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                if (e_pos == 6'(i)) begin
                    hit_d[i] = hit_q[i] + HW'(1);
                    if (hit_q[i] == HIT_MAX - HW'(1)) begin
                        blocks_left_d = blocks_left_q - 4'd1;
                    end
                end
            end
        end
    end

    // Render uses the pre-event hit state; bounds are widened to 11 bits so they cannot wrap.
    always_comb begin
        logic [10:0] px, py, bx, by, dx, dy;
        logic        border;
        block_on_d  = 1'b0;
        block_rgb_d = 8'h00;
        px = {1'b0, pixel_x};
        py = {1'b0, pixel_y};
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            bx = 11'(BLOCK_SPACING_X + (k % PER_ROW) * PITCH_X);
            by = (k < PER_ROW) ? 11'(FIRST_ROW_Y) : 11'(SECOND_ROW_Y);
            dx = px - bx;
            dy = py - by;
            border = (dx < 11'(BORDER_PIX)) || (dx > 11'(BLOCK_WIDTH - 1 - BORDER_PIX)) ||
                     (dy < 11'(BORDER_PIX)) || (dy > 11'(BLOCK_HEIGHT - 1 - BORDER_PIX));
            if (video_on && hit_q[k] < HIT_MAX &&
                px >= bx && px <= bx + 11'(BLOCK_WIDTH - 1) &&
                py >= by && py <= by + 11'(BLOCK_HEIGHT - 1)) begin
                block_on_d = 1'b1;
                case (hit_q[k])
                    HW'(0):  block_rgb_d = RGB_HIT0;
                    HW'(1):  block_rgb_d = RGB_HIT1;
                    default: block_rgb_d = RGB_HIT2;
                endcase
`ifdef BLOCK_BORDER_EN
                if (border) begin
                    block_rgb_d = RGB_BORDER;
                end
`else
                if (border && 1'b0) begin
                    block_rgb_d = RGB_BORDER;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                hit_q[i] <= '0;
            end
            prev_en_q     <= 1'b0;
            prev_pos_q    <= 6'd0;
            score_q       <= 10'd0;
            blocks_left_q <= 4'(NUM_BLOCKS);
            all_cleared_q <= 1'b0;
            block_on_q    <= 1'b0;
            block_rgb_q   <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                hit_q[i] <= hit_d[i];
            end
            prev_en_q     <= erase_enable;
            prev_pos_q    <= e_pos;
            score_q       <= score_d;
            blocks_left_q <= blocks_left_d;
            all_cleared_q <= (blocks_left_q == 4'd0);
            block_on_q    <= block_on_d;
            block_rgb_q   <= block_rgb_d;
        end
    end

    assign block_on    = block_on_q;
    assign block_rgb   = block_rgb_q;
    assign blocks_left = blocks_left_q;
    assign all_cleared = all_cleared_q;
    assign score       = score_q;

endmodule

// File: tb/tb_brick_field.sv
// Scoreboard bench for brick_field: a behavioural model predicts render and counters per cycle.
module tb_brick_field;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       erase_enable = 1'b0;
    logic [5:0] e_pos = 6'd0;
    logic [9:0] pixel_x = 10'd0;
    logic [9:0] pixel_y = 10'd0;
    logic       video_on = 1'b0;
    logic       block_on;
    logic [7:0] block_rgb;
    logic [3:0] blocks_left;
    logic       all_cleared;
    logic [9:0] score;

    brick_field dut (
        .clk(clk), .reset(reset), .erase_enable(erase_enable), .e_pos(e_pos),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .block_on(block_on), .block_rgb(block_rgb), .blocks_left(blocks_left),
        .all_cleared(all_cleared), .score(score)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int m_hit [10];
    int m_score = 0;
    int m_bl = 10;
    bit m_ac = 0;
    bit m_pen = 0;
    int m_ppos = 0;

    typedef struct { logic on; logic [7:0] rgb; int sc; int bl; logic ac; } exp_t;
    exp_t sb_q [$];

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_render(input int x, input int y, input bit von,
                                         output logic on, output logic [7:0] rgb);
        int bx, by;
        on = 0;
        rgb = 8'h00;
        if (!von) return;
        for (int k = 0; k < 10; k++) begin
            bx = 40 + (k % 5) * 120;
            by = (k < 5) ? 40 : 90;
            if (m_hit[k] < 3 && x >= bx && x <= bx + 79 && y >= by && y <= by + 29) begin
                on = 1;
                rgb = (m_hit[k] == 0) ? 8'hE0 : (m_hit[k] == 1) ? 8'hFC : 8'h1C;
`ifdef BLOCK_BORDER_EN
                if (x < bx + 2 || x > bx + 77 || y < by + 2 || y > by + 27) rgb = 8'hFF;
`endif
            end
        end
    endfunction

    task automatic step(input bit rst, input bit en, input int pos,
                        input int x, input int y, input bit von);
        exp_t e;
        bit ev, ac_new;
        @(negedge clk);
        reset = rst; erase_enable = en; e_pos = 6'(pos);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
        if (rst) begin
            e.on = 0; e.rgb = 8'h00;
            foreach (m_hit[i]) m_hit[i] = 0;
            m_score = 0; m_bl = 10; m_ac = 0; m_pen = 0; m_ppos = 0;
        end else begin
            model_render(x, y, von, e.on, e.rgb);
            ev = en && (!m_pen || pos != m_ppos);
            ac_new = (m_bl == 0);
            if (ev && pos < 10 && m_hit[pos] < 3) begin
                m_hit[pos]++;
                if (m_score < 1023) m_score++;
                if (m_hit[pos] == 3) m_bl--;
            end
            m_ac = ac_new;
            m_pen = en;
            m_ppos = pos;
        end
        e.sc = m_score; e.bl = m_bl; e.ac = m_ac;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("block_on", int'(block_on), int'(e.on));
        check("block_rgb", int'(block_rgb), int'(e.rgb));
        check("score", int'(score), e.sc);
        check("blocks_left", int'(blocks_left), e.bl);
        check("all_cleared", int'(all_cleared), int'(e.ac));
    endtask

    // Probe pixels: corners just inside and just outside each brick.
    task automatic edge_scan();
        int bx, by;
        for (int k = 0; k < 10; k++) begin
            bx = 40 + (k % 5) * 120;
            by = (k < 5) ? 40 : 90;
            step(0, 0, 0, bx, by, 1);
            step(0, 0, 0, bx + 79, by + 29, 1);
            step(0, 0, 0, bx - 1, by + 5, 1);
            step(0, 0, 0, bx + 80, by + 5, 1);
            step(0, 0, 0, bx + 10, by - 1, 1);
            step(0, 0, 0, bx + 10, by + 30, 1);
            step(0, 0, 0, bx + 2, by + 2, 1);
            step(0, 0, 0, bx + 40, by + 15, 1);
        end
    endtask

    initial begin
        foreach (m_hit[i]) m_hit[i] = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 45, 45, 1);
        step(0, 0, 0, 125, 45, 1);
        step(0, 0, 0, 45, 45, 0);
        edge_scan();

        for (int i = 0; i < 20; i++) step(0, 1, 3, 420, 55, 1);
        step(0, 0, 3, 420, 55, 1);

        for (int i = 0; i < 4; i++) begin
            step(0, 1, 7, 340, 105, 1);
            step(0, 0, 7, 340, 105, 1);
        end

        step(0, 1, 2, 160, 45, 1);
        step(0, 1, 2, 160, 45, 1);
        step(0, 1, 5, 45, 95, 1);
        step(0, 1, 5, 45, 95, 1);
        step(0, 1, 12, 45, 95, 1);
        step(0, 1, 12, 160, 45, 1);
        step(0, 0, 0, 160, 45, 1);
        edge_scan();

        for (int k = 0; k < 10; k++) begin
            while (m_hit[k] < 3) begin
                step(0, 1, k, 40 + (k % 5) * 120 + 1, ((k < 5) ? 40 : 90) + 1, 1);
                step(0, 0, k, 40 + (k % 5) * 120 + 5, ((k < 5) ? 40 : 90) + 5, 1);
            end
        end
        step(0, 0, 0, 45, 45, 1);
        step(0, 0, 0, 45, 45, 1);
        edge_scan();
        step(0, 1, 4, 500, 50, 1);

        step(1, 0, 0, 45, 45, 1);
        step(0, 0, 0, 45, 45, 1);
        edge_scan();

        step(0, 0, 1, 170, 50, 1);
        step(1, 1, 1, 170, 50, 1);
        step(0, 0, 1, 170, 50, 1);
        step(0, 0, 1, 170, 50, 1);

        for (int i = 0; i < 300; i++) begin
            step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
                 int'($urandom_range(0, 639)), int'($urandom_range(30, 130)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
